// File: rtl/motor_pkg.sv
// Shared definitions for the stepper controller: FSM encoding, coil phase
// table and default parameter values.
package motor_pkg;

  localparam int NCH_DEF   = 2;
  localparam int CNT_W_DEF = 16;
  localparam int DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Entry n is the coil pattern for phase index n (entry 0 sits in the LSBs).
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

endpackage

// File: rtl/motor_step_ctrl_if.sv
// Command channel of the stepper controller. A command transfers on a rising
// edge where cmd_valid=1 and cmd_ready=1; the payload is only sampled then.
interface motor_step_ctrl_if
  import motor_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic [NCH-1:0]   cmd_dir;
  logic             cmd_half;
  logic [DIV_W-1:0] cmd_div;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_half, cmd_div,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_half, cmd_div,
    output cmd_ready
  );

endinterface

// File: rtl/motor_phase_seq.sv
// One stepper channel: 3-bit phase index stepped up/down by 1 (half-step) or
// 2 (full-step), decoded to the 4-bit coil pattern.
module motor_phase_seq
  import motor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_lsb,
  input  logic       step,
  input  logic       dir,
  input  logic       half,
  output logic [3:0] coil
);

  logic [2:0] phase;
  logic [2:0] delta;

  assign delta = half ? 3'd1 : 3'd2;

  // Index wraps naturally modulo 8 through the 3-bit arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clear_lsb) begin
      phase <= {phase[2:1], 1'b0};
    end else if (step) begin
      phase <= dir ? (phase + delta) : (phase - delta);
    end
  end

  assign coil = PHASE_TABLE[phase];

endmodule

// File: rtl/motor_step_ctrl.sv
// Multi-channel stepper controller: IDLE/RUN/HOLD FSM, step-period prescaler
// and step counter driving NCH phase sequencers.
module motor_step_ctrl
  import motor_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  motor_step_ctrl_if.slave     cmd,
  input  logic                 abort,
  output logic [4*NCH-1:0]     coils,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic [CNT_W-1:0]     steps_done,
  output state_t               dbg_state
);

  state_t           state, next_state;
  logic [CNT_W-1:0] steps_q;
  logic [NCH-1:0]   dir_q;
  logic             half_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_eff;
  logic             accept;
  logic             step_evt;
  logic             last_step;
  logic             done_next;
  logic [4*NCH-1:0] coil_raw;

  assign cmd.cmd_ready = (state != ST_RUN) && !abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign div_eff       = (div_q == '0) ? DIV_W'(1) : div_q;
  // abort suppresses the step so steps_done and phases freeze on the abort edge
  assign step_evt      = (state == ST_RUN) && !abort && (presc == div_eff - DIV_W'(1));
  assign last_step     = step_evt && ((steps_done + CNT_W'(1)) == steps_q);

  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            next_state = (cmd.cmd_steps == '0) ? ST_HOLD : ST_RUN;
            done_next  = (cmd.cmd_steps == '0);
          end
        end
        ST_RUN: begin
          if (last_step) begin
            next_state = ST_HOLD;
            done_next  = 1'b1;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      steps_q    <= '0;
      dir_q      <= '0;
      half_q     <= 1'b0;
      div_q      <= '0;
      presc      <= '0;
      steps_done <= '0;
    end else begin
      state <= next_state;
      done  <= done_next;
      if (accept) begin
        steps_q    <= cmd.cmd_steps;
        dir_q      <= cmd.cmd_dir;
        half_q     <= cmd.cmd_half;
        div_q      <= cmd.cmd_div;
        presc      <= '0;
        steps_done <= '0;
      end else if (state == ST_RUN && !abort) begin
        if (step_evt) begin
          presc      <= '0;
          steps_done <= steps_done + CNT_W'(1);
        end else begin
          presc <= presc + DIV_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    motor_phase_seq u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_lsb (accept && !cmd.cmd_half),
      .step      (step_evt),
      .dir       (dir_q[i]),
      .half      (half_q),
      .coil      (coil_raw[4*i +: 4])
    );
  end

  assign coils     = (state == ST_IDLE) ? '0 : coil_raw;
  assign busy      = (state == ST_RUN);
  assign locked    = (state == ST_HOLD);
  assign dbg_state = state;

endmodule

// File: tb/tb_motor_step_ctrl.sv
// Bench for motor_step_ctrl: directed vector table, hand-written corner
// sequences and randomized commands checked against a step-timing model.
module tb_motor_step_ctrl;
  import motor_pkg::*;

  localparam int NCH   = 2;
  localparam int CNT_W = 10;
  localparam int DIV_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  motor_step_ctrl_if #(.NCH(NCH), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  logic             abort;
  logic [4*NCH-1:0] coils;
  logic             busy, done, locked;
  logic [CNT_W-1:0] steps_done;
  state_t           dbg_state;

  motor_step_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (bus.slave),
    .abort      (abort),
    .coils      (coils),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .steps_done (steps_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int m_phase [NCH];
  logic [3:0] coil_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [4*NCH-1:0] exp_coils();
    logic [4*NCH-1:0] e;
    for (int i = 0; i < NCH; i++) e[4*i +: 4] = coil_tab[m_phase[i]];
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    abort = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_steps = '0;
    bus.cmd_dir   = '0;
    bus.cmd_half  = 1'b0;
    bus.cmd_div   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_coils", coils, 0);
    check("rst_flags", {busy, done, locked}, 0);
    check("rst_steps_done", steps_done, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) m_phase[i] = 0;
  endtask

  // Issues one command from IDLE/HOLD and checks every cycle until the run
  // finishes; abort_cyc > 0 asserts abort on that clock count after accept.
  task automatic run_cmd(input int steps, input logic [NCH-1:0] dir, input logic half,
                         input int div, input int abort_cyc);
    int d, inc, total, k;
    int start [NCH];
    d = (div == 0) ? 1 : div;
    inc = half ? 1 : 2;
    total = steps * d;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = CNT_W'(steps);
    bus.cmd_dir   = dir;
    bus.cmd_half  = half;
    bus.cmd_div   = DIV_W'(div);
    #1 check("ready_before_cmd", bus.cmd_ready, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!half) m_phase[i] = m_phase[i] - (m_phase[i] % 2);
      start[i] = m_phase[i];
    end
    @(negedge clk);
    if (steps == 0) begin
      check("zero_done", done, 1);
      check("zero_locked_busy", {locked, busy}, 2'b10);
      check("zero_coils", coils, exp_coils());
      check("zero_steps_done", steps_done, 0);
      @(negedge clk);
      check("zero_done_drop", done, 0);
      return;
    end
    check("run_start_busy", busy, 1);
    check("run_start_coils", coils, exp_coils());
    check("run_start_steps_done", steps_done, 0);
    for (int c = 1; c <= total; c++) begin
      if (c == abort_cyc) begin
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = (c - 1) / d;
        for (int i = 0; i < NCH; i++)
          m_phase[i] = ((start[i] + (dir[i] ? 1 : -1) * inc * k) % 8 + 8) % 8;
        check("abort_coils", coils, 0);
        check("abort_flags", {busy, done, locked}, 0);
        check("abort_ready_low", bus.cmd_ready, 0);
        check("abort_steps_done", steps_done, k);
        check("abort_state", dbg_state, ST_IDLE);
        abort = 1'b0;
        #1 check("abort_ready_back", bus.cmd_ready, 1);
        return;
      end
      @(posedge clk);
      @(negedge clk);
      k = c / d;
      for (int i = 0; i < NCH; i++)
        m_phase[i] = ((start[i] + (dir[i] ? 1 : -1) * inc * k) % 8 + 8) % 8;
      check("run_coils", coils, exp_coils());
      check("run_steps_done", steps_done, k);
      if (c == total) begin
        check("end_flags", {busy, done, locked}, 3'b011);
      end else begin
        check("run_flags", {busy, done, locked}, 3'b100);
        check("run_ready_low", bus.cmd_ready, 0);
      end
    end
    @(negedge clk);
    check("hold_done_drop", done, 0);
    check("hold_ready", bus.cmd_ready, 1);
    check("hold_coils", coils, exp_coils());
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int               steps;
    logic [NCH-1:0]   dir;
    logic             half;
    int               div;
    logic [4*NCH-1:0] exp_coils_end;
    int               exp_steps_done;
  } vec_t;

  vec_t vecs [6];

  initial begin : main
    vecs[0] = '{4, 2'b01, 1'b0, 3, 8'h88, 4};
    vecs[1] = '{8, 2'b11, 1'b1, 1, 8'h88, 8};
    vecs[2] = '{3, 2'b01, 1'b1, 2, 8'h36, 3};
    vecs[3] = '{1, 2'b10, 1'b0, 0, 8'h41, 1};
    vecs[4] = '{5, 2'b00, 1'b1, 1, 8'h66, 5};
    vecs[5] = '{0, 2'b11, 1'b0, 2, 8'h88, 0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_cmd(vecs[v].steps, vecs[v].dir, vecs[v].half, vecs[v].div, 0);
      check($sformatf("vec%0d_coils", v), coils, vecs[v].exp_coils_end);
      check($sformatf("vec%0d_steps_done", v), steps_done, vecs[v].exp_steps_done);
    end

    // Reverse retrace from HOLD: 3 half-steps forward then 3 back.
    do_reset();
    run_cmd(3, 2'b11, 1'b1, 1, 0);
    check("fwd_coils", coils, 8'h66);
    run_cmd(3, 2'b00, 1'b1, 1, 0);
    check("retrace_coils", coils, 8'h88);

    // Abort at step 3 of 10, then confirm phases survive via a zero-step command.
    do_reset();
    run_cmd(10, 2'b11, 1'b0, 2, 7);
    check("abort_kept_steps", steps_done, 3);
    run_cmd(0, 2'b11, 1'b1, 1, 0);
    check("abort_kept_phase", coils, 8'h11);

    // Abort coinciding with a handshake in HOLD drops the command.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = CNT_W'(5);
    abort = 1'b1;
    #1 check("coincide_ready", bus.cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    abort = 1'b0;
    check("coincide_flags", {busy, done, locked}, 0);
    check("coincide_coils", coils, 0);
    check("coincide_steps_done", steps_done, 0);

    // Asynchronous reset between edges mid-run.
    run_cmd(0, 2'b00, 1'b0, 1, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = CNT_W'(10);
    bus.cmd_half  = 1'b1;
    bus.cmd_div   = DIV_W'(1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_coils", coils, 0);
    check("async_flags", {busy, done, locked}, 0);
    check("async_steps_done", steps_done, 0);
    check("async_ready", bus.cmd_ready, 1);
    do_reset();

    // Maximum step count runs to completion without wrapping.
    run_cmd((1 << CNT_W) - 1, 2'b10, 1'b1, 1, 0);
    check("max_steps_done", steps_done, (1 << CNT_W) - 1);

    // Randomized command stream with occasional aborts.
    for (int r = 0; r < 30; r++) begin
      int st, dv, ac;
      st = $urandom_range(0, 10);
      dv = $urandom_range(0, 3);
      ac = 0;
      if (st > 0 && $urandom_range(0, 4) == 0)
        ac = $urandom_range(1, st * ((dv == 0) ? 1 : dv));
      run_cmd(st, NCH'($urandom), 1'($urandom), dv, ac);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
